// File: rtl/imm_ext_pkg.sv
// Mode encodings for the immediate extender, shared with the control unit.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'd0,
    MODE_SIGN   = 2'd1,
    MODE_LUI    = 2'd2,
    MODE_BRANCH = 2'd3
  } mode_e;

  localparam int MODE_W  = 2;
  localparam int COUNT_W = 16;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: zero, sign, LUI shift, branch-offset shift.
// No latency, no state; backpressure is handled by the enclosing pipe.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int LUI_SH = 16,
  parameter int BR_SH  = 2
) (
  input  logic [IN_W-1:0]   imm,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  ext
);

  if (OUT_W < IN_W + 2) begin : g_bad_out_w
    $error("imm_ext_core: OUT_W must be at least IN_W+2");
  end
  if (LUI_SH + IN_W > OUT_W) begin : g_bad_lui_sh
    $error("imm_ext_core: LUI_SH+IN_W must not exceed OUT_W");
  end

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign zext = {{(OUT_W-IN_W){1'b0}}, imm};
  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  // Shifts are evaluated at OUT_W, so bits pushed past the top are dropped.
  always_comb begin
    ext = zext;
    case (mode_e'(mode))
      MODE_ZERO:   ext = zext;
      MODE_SIGN:   ext = sext;
      MODE_LUI:    ext = zext << LUI_SH;
      MODE_BRANCH: ext = sext << BR_SH;
      default:     ext = zext;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender behind valid/ready with a 2-entry skid buffer.
// Latency 1 cycle; in_ready comes straight from the skid flag, never from out_ready.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int LUI_SH = 16,
  parameter int BR_SH  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_imm,
  input  logic [MODE_W-1:0]   in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic [MODE_W-1:0]   out_mode,
  output logic [COUNT_W-1:0]  ext_count
);

  logic [OUT_W-1:0]  ext;
  logic              skid_valid;
  logic [OUT_W-1:0]  skid_data;
  logic [MODE_W-1:0] skid_mode;
  logic              accept;
  logic              deliver;

  imm_ext_core #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .LUI_SH (LUI_SH),
    .BR_SH  (BR_SH)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (ext)
  );

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_mode   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_mode  <= '0;
      ext_count  <= '0;
    end else begin
      if (deliver) begin
        ext_count <= ext_count + 16'd1;
      end
      // Accept cannot coincide with a full skid, so the branches are exclusive.
      if (skid_valid && deliver) begin
        out_data   <= skid_data;
        out_mode   <= skid_mode;
        skid_valid <= 1'b0;
      end else if (accept && (!out_valid || deliver)) begin
        out_data  <= ext;
        out_mode  <= in_mode;
        out_valid <= 1'b1;
      end else if (accept) begin
        skid_data  <= ext;
        skid_mode  <= in_mode;
        skid_valid <= 1'b1;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: default 16->32 instance plus an 8->16 instance.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
  logic [15:0] ext_count;

  logic        p_in_valid;
  logic        p_in_ready;
  logic [7:0]  p_in_imm;
  logic [1:0]  p_in_mode;
  logic        p_out_valid;
  logic        p_out_ready;
  logic [15:0] p_out_data;
  logic [1:0]  p_out_mode;
  logic [15:0] p_ext_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_ext_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .ext_count (ext_count)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16), .LUI_SH(8), .BR_SH(1)) dut_p (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (p_in_valid),
    .in_ready  (p_in_ready),
    .in_imm    (p_in_imm),
    .in_mode   (p_in_mode),
    .out_valid (p_out_valid),
    .out_ready (p_out_ready),
    .out_data  (p_out_data),
    .out_mode  (p_out_mode),
    .ext_count (p_ext_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] imm, input logic [1:0] mode);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
  endtask

  logic [15:0] sweep_imm;
  logic [31:0] sweep_exp [4];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
    p_in_valid = 1'b0; p_in_imm = '0; p_in_mode = '0; p_out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_out_mode",  {30'd0, out_mode},  32'd0);
    chk("rst_count",     {16'd0, ext_count}, 32'd0);

    // Parametrised instance: 8->16
    p_in_valid = 1'b1; p_in_imm = 8'h80; p_in_mode = 2'd3;
    tick();
    chk("p_branch", {16'd0, p_out_data}, 32'h0000FF00);
    p_in_imm = 8'h12; p_in_mode = 2'd2;
    tick();
    chk("p_lui", {16'd0, p_out_data}, 32'h00001200);
    p_in_valid = 1'b0;
    tick();

    // Single SIGN push
    out_ready = 1'b1;
    push(16'h8004, 2'd1);
    tick();
    in_valid = 1'b0;
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_data",  out_data,           32'hFFFF8004);
    chk("t1_mode",  {30'd0, out_mode},  32'd1);
    tick();
    chk("t1_count", {16'd0, ext_count}, 32'd1);
    chk("t1_idle",  {31'd0, out_valid}, 32'd0);

    // Mode sweep, back-to-back
    sweep_imm = 16'hABCD;
    sweep_exp[0] = 32'h0000ABCD;
    sweep_exp[1] = 32'hFFFFABCD;
    sweep_exp[2] = 32'hABCD0000;
    sweep_exp[3] = 32'hFFFEAF34;
    for (int m = 0; m < 4; m++) begin
      push(sweep_imm, 2'(m));
      tick();
      chk($sformatf("sweep_data_m%0d", m), out_data, sweep_exp[m]);
      chk($sformatf("sweep_mode_m%0d", m), {30'd0, out_mode}, 32'(m));
      chk($sformatf("sweep_rdy_m%0d", m),  {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("sweep_count", {16'd0, ext_count}, 32'd5);

    // Backpressure: A then B with out_ready low
    out_ready = 1'b0;
    push(16'h0001, 2'd0);
    tick();
    push(16'h0002, 2'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_a",   out_data,          32'h00000001);
    tick();
    chk("bp_stable_a", out_data,           32'h00000001);
    chk("bp_valid",    {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_b_next",   out_data,           32'h00000002);
    chk("bp_rdy_back", {31'd0, in_ready},  32'd1);
    chk("bp_count_a",  {16'd0, ext_count}, 32'd6);
    tick();
    chk("bp_drained",  {31'd0, out_valid}, 32'd0);
    chk("bp_count_b",  {16'd0, ext_count}, 32'd7);

    // Reset with both entries full
    out_ready = 1'b0;
    push(16'h1111, 2'd0);
    tick();
    push(16'h2222, 2'd0);
    tick();
    in_valid = 1'b0;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_ready", {31'd0, in_ready},  32'd1);
    chk("mrst_count", {16'd0, ext_count}, 32'd0);
    out_ready = 1'b1;
    push(16'h7FFF, 2'd1);
    tick();
    in_valid = 1'b0;
    chk("mrst_sign", out_data, 32'h00007FFF);
    tick();
    chk("mrst_no_stale", {31'd0, out_valid}, 32'd0);

    // Counter wrap: stream from a fresh reset, one deliver per cycle after the first
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push(16'h0000, 2'd0);
    out_ready = 1'b1;
    repeat (65536) tick();
    chk("wrap_ffff", {16'd0, ext_count}, 32'h0000FFFF);
    tick();
    chk("wrap_zero", {16'd0, ext_count}, 32'h00000000);
    in_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
